w0rm_peripheral_uart_tx: RTL

//  Memory-mapped UART transmitter that responds on the W0RM data-memory bus, alongside the GPIO peripheral.
//  The core pushes bytes into a TX FIFO, and the block serialises them as 8N1 on tx_o.
//  Its response port feeds a W0RM_Peripheral_Bus_Extender input.
//  It is a responder only and never initiates bus cycles.

---
 rtl/w0rm_peripheral_uart_tx.sv | 321 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/w0rm_peripheral_uart_tx.sv
// -----------------------------------------------------------------------------
// w0rm_peripheral_uart_tx
//
// Memory-mapped 8N1 UART transmitter on the W0RM data-memory bus. The core
// writes bytes into a small TX FIFO and the serialiser shifts them out LSB
// first on tx_o. The block only responds to bus requests and never starts one.
//
// Register window (16 bytes at BASE_ADDR, offset = addr[3:2]):
//   0x0 DATA     W: push mem_data_i[7:0]          R: 0
//   0x4 STATUS   R: [0] full, [1] empty, [2] busy, [3] overflow (sticky),
//                   [15:8] FIFO count            W: bit3=1 clears overflow
//   0x8 DIVISOR  R/W [15:0], bit period in mem_clk cycles (0 behaves as 1)
//   0xC reserved R: 0, W: ignored (still acknowledged)
//
// Ports:
//   mem_clk      in   1           sole clock, everything on posedge
//   reset        in   1           synchronous, active-high
//   mem_valid_i  in   1           request strobe
//   mem_read_i   in   1           read request
//   mem_write_i  in   1           write request
//   mem_addr_i   in   ADDR_WIDTH  byte address
//   mem_data_i   in   DATA_WIDTH  write data
//   mem_valid_o  out  1           response strobe, one cycle after a hit
//   mem_data_o   out  DATA_WIDTH  read data, zero whenever mem_valid_o=0
//   tx_o         out  1           serial output, idle high
// -----------------------------------------------------------------------------
module w0rm_peripheral_uart_tx #(
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 32'h8000_0100,
    parameter int unsigned           FIFO_DEPTH      = 8,
    parameter logic [15:0]           DEFAULT_DIVISOR = 16'd868
) (
    input  logic                  mem_clk,
    input  logic                  reset,
    input  logic                  mem_valid_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  mem_valid_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  tx_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        REG_DATA    = 2'd0,
        REG_STATUS  = 2'd1,
        REG_DIVISOR = 2'd2,
        REG_RSVD    = 2'd3
    } reg_offset_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    // ------------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------------
    logic        w_hit;
    logic        w_wr_hit;
    logic        w_rd_hit;
    reg_offset_t w_offset;
    logic        w_push_req;

    assign w_hit = mem_valid_i && (mem_read_i || mem_write_i) &&
                   (mem_addr_i[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
    assign w_wr_hit   = w_hit && mem_write_i;
    assign w_rd_hit   = w_hit && mem_read_i;
    assign w_offset   = reg_offset_t'(mem_addr_i[3:2]);
    assign w_push_req = w_wr_hit && (w_offset == REG_DATA);

    // Byte-lane bits of the address and the unused upper write-data bits carry
    // no meaning here; collecting them keeps the intent explicit.
    logic w_unused;
    assign w_unused = &{1'b0, mem_addr_i[1:0], mem_data_i};

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    logic [15:0] r_divisor;
    logic        r_overflow;
    logic [15:0] w_div_eff;

    // ------------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------------
    logic [7:0]       r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_overflow_set;

    assign w_full  = (r_count == FIFO_FULL_CNT);
    assign w_empty = (r_count == '0);
    // A full FIFO still takes a byte when the serialiser pops in the same cycle.
    assign w_push         = w_push_req && (!w_full || w_pop);
    assign w_overflow_set = w_push_req && w_full && !w_pop;

    // A divisor of zero would mean a zero-length bit; treat it as one cycle.
    assign w_div_eff = (r_divisor == 16'd0) ? 16'd1 : r_divisor;

    // ------------------------------------------------------------------------
    // Serialiser state
    // ------------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_next;
    logic [15:0] r_period;
    logic [15:0] w_period_next;
    logic [15:0] r_baud_cnt;
    logic [15:0] w_baud_cnt_next;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_bit_idx_next;
    logic        r_tx;
    logic        w_tx_next;
    logic        w_tick;

    // Last cycle of the current START/DATA/STOP slot.
    assign w_tick = (r_baud_cnt == 16'd0);

    // ------------------------------------------------------------------------
    // Read data mux: sees register state before this cycle's own updates.
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_status;
    logic [DATA_WIDTH-1:0] w_rdata;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_status       = '0;
        w_status[0]    = w_full;
        w_status[1]    = w_empty;
        w_status[2]    = (r_state != ST_IDLE);
        w_status[3]    = r_overflow;
        w_status[15:8] = 8'(r_count);

        w_rdata = '0;
        case (w_offset)
            REG_STATUS:  w_rdata = w_status;
            REG_DIVISOR: w_rdata = DATA_WIDTH'(r_divisor);
            default:     w_rdata = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Bus response: one cycle after every hit, data only for reads.
    // ------------------------------------------------------------------------
    logic                  r_valid_o;
    logic [DATA_WIDTH-1:0] r_data_o;

    always_ff @(posedge mem_clk) begin
        if (reset) begin
            r_valid_o <= 1'b0;
            r_data_o  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            r_valid_o <= w_hit;
            r_data_o  <= w_rd_hit ? w_rdata : '0;
        end
    end

    assign mem_valid_o = r_valid_o;
    assign mem_data_o  = r_data_o;

    // ------------------------------------------------------------------------
    // Divisor and sticky overflow
    // ------------------------------------------------------------------------
    always_ff @(posedge mem_clk) begin
        if (reset) begin
            r_divisor  <= DEFAULT_DIVISOR;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_hit && (w_offset == REG_DIVISOR)) begin
                r_divisor <= mem_data_i[15:0];
            end
            if (w_overflow_set) begin
                r_overflow <= 1'b1;
            end else if (w_wr_hit && (w_offset == REG_STATUS) && mem_data_i[3]) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------------
    always_ff @(posedge mem_clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the FIFO storage has no reset; occupancy is tracked by the
    // pointers and count, so stale contents are never observed.
    always_ff @(posedge mem_clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= mem_data_i[7:0];
        end
    end

    // ------------------------------------------------------------------------
    // Serialiser FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge mem_clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_period   <= 16'd1;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_period   <= w_period_next;
            r_baud_cnt <= w_baud_cnt_next;
            r_bit_idx  <= w_bit_idx_next;
            r_tx       <= w_tx_next;
        end
    end

    // ------------------------------------------------------------------------
    // Serialiser FSM: next state, pop request and registered line level
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_period_next   = r_period;
        w_baud_cnt_next = r_baud_cnt;
        w_bit_idx_next  = r_bit_idx;
        w_pop           = 1'b0;
        w_tx_next       = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_next    = ST_DATA;
                    w_baud_cnt_next = r_period - 16'd1;
                end else begin
                    w_baud_cnt_next = r_baud_cnt - 16'd1;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_baud_cnt_next = r_period - 16'd1;
                    w_shift_next    = {1'b0, r_shift[7:1]};
                    w_bit_idx_next  = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = ST_STOP;
                    end
                end else begin
                    w_baud_cnt_next = r_baud_cnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    // Chaining straight into the next START avoids an idle gap.
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_baud_cnt_next = r_baud_cnt - 16'd1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        // Frame start: the bit period is captured here, so a divisor write
        // during a frame only affects the next one.
        if (w_pop) begin
            w_shift_next    = r_fifo_mem[r_rd_ptr];
            w_period_next   = w_div_eff;
            w_baud_cnt_next = w_div_eff - 16'd1;
            w_bit_idx_next  = 3'd0;
        end

        // The line level is registered from the next state so tx_o is a clean
        // flop output that changes on the same edge as the state.
        case (w_state_next)
            ST_START: w_tx_next = 1'b0;
            ST_DATA:  w_tx_next = w_shift_next[0];
            default:  w_tx_next = 1'b1;
        endcase
    end

    assign tx_o = r_tx;

endmodule
